// File: rtl/bp_stream_lock_arbiter.sv
// bp_stream_lock_arbiter: round-robin, per-message arbiter sharing one BP Stream
// client port among num_masters_p masters. Pass-through with no storage; a
// master's lock holds the grant until the last beat of its message transfers.
module bp_stream_lock_arbiter #(
  parameter int unsigned num_masters_p  = 2,
  parameter int unsigned data_width_p   = 64,
  parameter int unsigned paddr_width_p  = 40,
  parameter int unsigned lce_id_width_p = 4,
  parameter int unsigned lce_assoc_p    = 8,
  localparam int unsigned way_width_lp    = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  // msg_type(4) + subop(4) + addr + size(3) + lce_id + way_id + coh_state(3)
  localparam int unsigned header_width_lp = 4 + 4 + paddr_width_p + 3 + lce_id_width_p
                                            + way_width_lp + 3,
  localparam int unsigned id_width_lp     = (num_masters_p > 1) ? $clog2(num_masters_p) : 1
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic [num_masters_p*header_width_lp-1:0] mem_header_i,
  input  logic [num_masters_p*data_width_p-1:0]    mem_data_i,
  input  logic [num_masters_p-1:0]                 mem_v_i,
  input  logic [num_masters_p-1:0]                 mem_lock_i,
  output logic [num_masters_p-1:0]                 mem_ready_o,
  output logic [header_width_lp-1:0]               mem_header_o,
  output logic [data_width_p-1:0]                  mem_data_o,
  output logic                                     mem_v_o,
  input  logic                                     mem_ready_i,
  output logic                                     mem_lock_o,
  output logic [id_width_lp-1:0]                   grant_id_o,
  output logic                                     grant_v_o
);

  typedef enum logic {e_idle, e_locked} state_e;

  state_e                 state_r;
  logic [id_width_lp-1:0] owner_r;
  logic [id_width_lp-1:0] last_r;
  logic [id_width_lp-1:0] winner;
  logic                   search_found;
  int unsigned            search_idx;
  logic                   fire;

  // Winner select: the locked owner, else first valid after last_r with explicit wrap
  always_comb begin
    winner       = last_r;
    search_found = 1'b0;
    search_idx   = 0;
    if (state_r == e_locked) begin
      winner = owner_r;
    end else begin
      for (int unsigned k = 1; k <= num_masters_p; k++) begin
        search_idx = 32'(last_r) + k;
        if (search_idx >= num_masters_p) search_idx = search_idx - num_masters_p;
        if (!search_found && mem_v_i[id_width_lp'(search_idx)]) begin
          search_found = 1'b1;
          winner       = id_width_lp'(search_idx);
        end
      end
    end
  end

  // Payload mux from the winning master's slice
  always_comb begin
    mem_header_o = '0;
    mem_data_o   = '0;
    for (int unsigned i = 0; i < num_masters_p; i++) begin
      if (winner == id_width_lp'(i)) begin
        mem_header_o = mem_header_i[i*header_width_lp +: header_width_lp];
        mem_data_o   = mem_data_i[i*data_width_p +: data_width_p];
      end
    end
  end

  // Ready routed back to the winner only; nothing is granted while reset is held
  always_comb begin
    mem_ready_o         = '0;
    mem_ready_o[winner] = reset_n_i & mem_ready_i;
  end

  // Handshake and grant reporting; mem_v_o has no dependence on mem_ready_i
  assign mem_v_o    = reset_n_i & mem_v_i[winner];
  assign mem_lock_o = reset_n_i & mem_lock_i[winner];
  assign grant_id_o = winner;
  assign grant_v_o  = reset_n_i & (mem_v_i[winner] | (state_r == e_locked));
  assign fire       = mem_v_o & mem_ready_i;

  // Message FSM: lock on a non-final beat, release and advance pointer on the last beat
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      owner_r <= '0;
      last_r  <= id_width_lp'(num_masters_p - 1);
    end else if (fire) begin
      if (mem_lock_o) begin
        state_r <= e_locked;
        owner_r <= winner;
      end else begin
        state_r <= e_idle;
        last_r  <= winner;
      end
    end
  end

  // Configuration sanity check
  if (num_masters_p < 2) begin : g_num_masters_check
    $error("bp_stream_lock_arbiter: num_masters_p must be >= 2");
  end

  // Owner's header must hold while it waits on a stalled client inside a message
  a_header_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_r == e_locked && mem_v_o && !mem_ready_i) |=> (!mem_v_o || $stable(mem_header_o)))
    else $error("bp_stream_lock_arbiter: header changed while stalled");

endmodule
